// File: rtl/skywater_lvlshift_rx_sync.sv
// Receive-side synchronizer for a bank of up-level-shifted signals.
// Isolates the shifter outputs while the source supply is absent or settling,
// synchronizes and glitch-filters every bit, and reports clean edges.
module skywater_lvlshift_rx_sync #(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int FILT_CYCLES   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_pwr_good,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             active,
    output logic             iso_en
);

    localparam int FCW = $clog2(FILT_CYCLES + 1);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [FCW-1:0] FILT_LAST   = FCW'(FILT_CYCLES - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ISO    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Synchronizer chains: index 0 is the first flop, the last index feeds logic.
    logic [SYNC_STAGES-1:0]            pg_sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] din_sync_q;
    logic                              pg_s;
    logic [WIDTH-1:0]                  din_s;

    state_t                      state_q, state_d;
    logic [SCW-1:0]              settle_cnt_q, settle_cnt_d;
    logic [WIDTH-1:0][FCW-1:0]   filt_cnt_q, filt_cnt_d;
    logic [WIDTH-1:0]            data_out_q, data_out_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic                        active_q;
    logic                        iso_en_q;

    assign pg_s  = pg_sync_q[SYNC_STAGES-1];
    assign din_s = din_sync_q[SYNC_STAGES-1];

    // Multi-flop synchronizers for power-good and data; they run in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pg_sync_q  <= '0;
            din_sync_q <= '0;
        end else begin
            pg_sync_q  <= {pg_sync_q[SYNC_STAGES-2:0], in_pwr_good};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], data_in};
        end
    end

    // Isolation sequencing, settle counting and per-bit glitch filtering.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        filt_cnt_d   = filt_cnt_q;
        data_out_d   = data_out_q;
        rise_d       = '0;
        fall_d       = '0;

        case (state_q)
            ST_ISO: begin
                settle_cnt_d = '0;
                filt_cnt_d   = '0;
                data_out_d   = '0;
                if (pg_s) begin
                    // The edge that first sees pg_s high is itself one good cycle.
                    if (SETTLE_CYCLES == 1) begin
                        state_d    = ST_ACTIVE;
                        data_out_d = din_s;
                    end else begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SCW'(1);
                    end
                end else begin
                    state_d = ST_ISO;
                end
            end

            ST_SETTLE: begin
                filt_cnt_d = '0;
                data_out_d = '0;
                if (!pg_s) begin
                    state_d      = ST_ISO;
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    // Initial load is taken as-is with no edge pulses.
                    state_d      = ST_ACTIVE;
                    settle_cnt_d = '0;
                    data_out_d   = din_s;
                end else begin
                    settle_cnt_d = settle_cnt_q + SCW'(1);
                end
            end

            ST_ACTIVE: begin
                settle_cnt_d = '0;
                if (!pg_s) begin
                    // Supply loss clamps immediately, silently, mid-filter or not.
                    state_d    = ST_ISO;
                    filt_cnt_d = '0;
                    data_out_d = '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (din_s[i] != data_out_q[i]) begin
                            if (filt_cnt_q[i] == FILT_LAST) begin
                                data_out_d[i] = din_s[i];
                                filt_cnt_d[i] = '0;
                                rise_d[i]     = din_s[i];
                                fall_d[i]     = ~din_s[i];
                            end else begin
                                filt_cnt_d[i] = filt_cnt_q[i] + FCW'(1);
                            end
                        end else begin
                            filt_cnt_d[i] = '0;
                        end
                    end
                end
            end

            default: begin
                state_d      = ST_ISO;
                settle_cnt_d = '0;
                filt_cnt_d   = '0;
                data_out_d   = '0;
            end
        endcase
    end

    // State and registered outputs; reset forces isolation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ISO;
            settle_cnt_q <= '0;
            filt_cnt_q   <= '0;
            data_out_q   <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            active_q     <= 1'b0;
            iso_en_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            filt_cnt_q   <= filt_cnt_d;
            data_out_q   <= data_out_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            active_q     <= (state_d == ST_ACTIVE);
            iso_en_q     <= (state_d != ST_ACTIVE);
        end
    end

    assign data_out = data_out_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign active   = active_q;
    assign iso_en   = iso_en_q;

endmodule

// File: tb/tb_skywater_lvlshift_rx_sync.sv
// Bench for skywater_lvlshift_rx_sync: directed scenarios plus random traffic,
// every cycle compared against a rule-level model of the receiver.
module tb_skywater_lvlshift_rx_sync;

    localparam int W      = 4;
    localparam int SYNC   = 2;
    localparam int SETTLE = 16;
    localparam int FILT   = 3;

    logic         clk;
    logic         rst;
    logic         in_pwr_good;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         active;
    logic         iso_en;

    int checks   = 0;
    int failures = 0;

    skywater_lvlshift_rx_sync #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .FILT_CYCLES(FILT)
    ) dut (
        .clk(clk), .rst(rst), .in_pwr_good(in_pwr_good), .data_in(data_in),
        .data_out(data_out), .rise(rise), .fall(fall), .active(active), .iso_en(iso_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: raw input history plus rule-level bookkeeping.
    logic         pg_hist  [SYNC];
    logic [W-1:0] din_hist [SYNC];
    int           good_run;
    int           diff_run [W];
    logic [W-1:0] m_out, m_rise, m_fall;
    logic         m_active;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock edge of the model: the output is active once the synchronized
    // power-good has been seen high SETTLE consecutive edges in a row.
    task automatic model_edge(input logic r, input logic pg, input logic [W-1:0] d);
        logic         pg_s_m;
        logic [W-1:0] ds;
        logic         was_active;
        if (r) begin
            for (int i = 0; i < SYNC; i++) begin
                pg_hist[i]  = 1'b0;
                din_hist[i] = '0;
            end
            good_run = 0;
            for (int b = 0; b < W; b++) diff_run[b] = 0;
            m_out = '0; m_rise = '0; m_fall = '0; m_active = 1'b0;
        end else begin
            pg_s_m     = pg_hist[SYNC-1];
            ds         = din_hist[SYNC-1];
            was_active = (good_run >= SETTLE);
            if (pg_s_m) good_run = (good_run < SETTLE) ? good_run + 1 : good_run;
            else        good_run = 0;
            m_active = (good_run >= SETTLE);
            m_rise = '0;
            m_fall = '0;
            if (!m_active) begin
                m_out = '0;
                for (int b = 0; b < W; b++) diff_run[b] = 0;
            end else if (!was_active) begin
                m_out = ds;
                for (int b = 0; b < W; b++) diff_run[b] = 0;
            end else begin
                for (int b = 0; b < W; b++) begin
                    if (ds[b] != m_out[b]) begin
                        diff_run[b]++;
                        if (diff_run[b] == FILT) begin
                            m_out[b] = ds[b];
                            if (ds[b]) m_rise[b] = 1'b1;
                            else       m_fall[b] = 1'b1;
                            diff_run[b] = 0;
                        end
                    end else begin
                        diff_run[b] = 0;
                    end
                end
            end
            for (int i = SYNC - 1; i > 0; i--) begin
                pg_hist[i]  = pg_hist[i-1];
                din_hist[i] = din_hist[i-1];
            end
            pg_hist[0]  = pg;
            din_hist[0] = d;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic pg, input logic [W-1:0] d);
        rst         = r;
        in_pwr_good = pg;
        data_in     = d;
        @(posedge clk);
        model_edge(r, pg, d);
        #1;
        chk("active",   32'(active),   32'(m_active));
        chk("iso_en",   32'(iso_en),   32'(!m_active));
        chk("data_out", 32'(data_out), 32'(m_out));
        chk("rise",     32'(rise),     32'(m_rise));
        chk("fall",     32'(fall),     32'(m_fall));
    endtask

    task automatic hold(input int n, input logic pg, input logic [W-1:0] d);
        for (int k = 0; k < n; k++) step(1'b0, pg, d);
    endtask

    initial begin
        int           first_edge;
        logic [W-1:0] d;
        logic         pg;
        logic         r;
        int           len;

        rst = 1'b1; in_pwr_good = 1'b0; data_in = '0;
        #2;
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b0000);
        chk("reset_iso_en", 32'(iso_en), 32'd1);
        chk("reset_active", 32'(active), 32'd0);

        // Power-up settle: active must rise on edge SYNC+SETTLE counting the first sample as edge 1.
        first_edge = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b1, 4'b1010);
            if (active === 1'b1 && first_edge == 0) first_edge = k;
        end
        chk("settle_edge", 32'(first_edge), 32'(SYNC + SETTLE));
        chk("initial_load", 32'(data_out), 32'(4'b1010));

        // Bit 0 rise, then all ones.
        hold(8, 1'b1, 4'b1011);
        hold(8, 1'b1, 4'b1111);

        // Bit 2 low glitches of 1, 2 and 3 cycles.
        hold(1, 1'b1, 4'b1011); hold(6, 1'b1, 4'b1111);
        hold(2, 1'b1, 4'b1011); hold(6, 1'b1, 4'b1111);
        chk("glitch_rejected", 32'(data_out), 32'(4'b1111));
        hold(3, 1'b1, 4'b1011); hold(6, 1'b1, 4'b1011);
        chk("glitch_accepted", 32'(data_out), 32'(4'b1011));

        // Supply drop with all ones: silent clamp.
        hold(6, 1'b1, 4'b1111);
        hold(6, 1'b0, 4'b1111);
        chk("drop_clamped", 32'(data_out), 32'd0);

        // Settle interrupted at count 10 by a one-cycle power-good dip.
        hold(12, 1'b1, 4'b0110);
        hold(1, 1'b0, 4'b0110);
        first_edge = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b1, 4'b0110);
            if (active === 1'b1 && first_edge == 0) first_edge = k;
        end
        chk("resettle_edge", 32'(first_edge), 32'(SYNC + SETTLE));

        // Reset mid-filter, then a full re-settle.
        hold(3, 1'b1, 4'b1001);
        step(1'b1, 1'b1, 4'b1001);
        chk("rst_iso_en", 32'(iso_en), 32'd1);
        chk("rst_data_out", 32'(data_out), 32'd0);
        first_edge = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b1, 4'b1001);
            if (active === 1'b1 && first_edge == 0) first_edge = k;
        end
        chk("rst_resettle_edge", 32'(first_edge), 32'(SYNC + SETTLE));

        // Random traffic: bursty data, rare supply dips and rare resets.
        d = 4'b1001;
        for (int ph = 0; ph < 120; ph++) begin
            len = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) d = d ^ 4'($urandom_range(1, 15));
            else d = d ^ (4'b0001 << $urandom_range(0, W - 1));
            pg = ($urandom_range(0, 24) != 0);
            r  = ($urandom_range(0, 60) == 0);
            step(r, pg, d);
            for (int k = 1; k < len; k++) step(1'b0, pg, d);
            if (ph % 30 == 29) hold(SYNC + SETTLE + 2, 1'b1, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
